// File: rtl/locator_pkg.sv
// Shared definitions for the weight streamer: default word width, a constant
// clog2, the FSM state encoding and the popcount used when a word is loaded.
package locator_pkg;

  localparam int unsigned DEFAULT_W = 8;
  localparam int unsigned MAX_W     = 64;
  localparam int unsigned PC_MAX_W  = 7;   // holds popcount of a MAX_W word

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of set bits; callers zero-extend their word to MAX_W.
  function automatic logic [PC_MAX_W-1:0] popcount(input logic [MAX_W-1:0] word);
    logic [PC_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(MAX_W); i++) begin
      n = n + PC_MAX_W'(word[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// Lowest-set-bit locator (combinational).
//   vec     : word to scan
//   index   : bit position of the lowest set bit (0 when vec is zero)
//   isolate : one-hot of that bit (zero when vec is zero), used to clear it
module lowest_set_bit
  import locator_pkg::*;
#(
  parameter  int unsigned W  = DEFAULT_W,
  localparam int unsigned LW = clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [LW-1:0] index,
  output logic [W-1:0]  isolate
);

  // Two's-complement trick keeps only the lowest set bit.
  assign isolate = vec & (~vec + W'(1));

  // Scan downward so the lowest set bit is the last to write.
  always_comb begin
    index = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec[i]) index = LW'(i);
    end
  end

endmodule

// File: rtl/weight_streamer.sv
// Weight streamer: accepts a word and emits one beat per set bit, lowest
// first, with the bit position, beat ordinal and the word's popcount.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake, in_data is the word
//   pos_valid/pos_ready: beat handshake
//   pos, pos_idx       : bit index and ordinal of the current beat
//   pos_last           : final beat of the word
//   pos_empty          : word had no set bits (single beat)
//   pc                 : registered popcount of the word being emitted
module weight_streamer
  import locator_pkg::*;
#(
  parameter  int unsigned W  = DEFAULT_W,
  localparam int unsigned LW = clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic [LW:0]   pc,
  output logic          pos_valid,
  input  logic          pos_ready,
  output logic [LW-1:0] pos,
  output logic [LW-1:0] pos_idx,
  output logic          pos_last,
  output logic          pos_empty
);

  state_t        state_q, state_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [LW:0]   pc_q, pc_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] low_index;
  logic [W-1:0]  low_isolate;
  logic          emitting;
  logic          beat_hs;
  logic          in_hs;

  lowest_set_bit #(.W(W)) u_lsb (
    .vec     (mask_q),
    .index   (low_index),
    .isolate (low_isolate)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    pc_d     = pc_q;
    idx_d    = idx_q;

    emitting  = (state_q == EMIT);
    pos_valid = emitting;
    pos_empty = emitting && (mask_q == '0);
    // Mask equal to its own lowest bit: one bit left, or none (empty word).
    pos_last  = emitting && (mask_q == low_isolate);
    pos       = emitting ? low_index : '0;
    pos_idx   = emitting ? idx_q : '0;

    beat_hs  = pos_valid && pos_ready;
    // Accept a new word while idle or in the same cycle the last beat leaves.
    in_ready = !rst && (!emitting || (beat_hs && pos_last));
    in_hs    = in_valid && in_ready;

    if (in_hs) begin
      mask_d  = in_data;
      pc_d    = (LW+1)'(popcount(MAX_W'(in_data)));
      idx_d   = '0;
      state_d = EMIT;
    end else if (beat_hs) begin
      mask_d = mask_q & ~low_isolate;
      idx_d  = idx_q + LW'(1);
      if (pos_last) state_d = IDLE;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_weight_streamer.sv
// Bench for weight_streamer: W=8 and W=16 instances, expected beats queued
// from a bit-scan model when a word is driven, observed beats captured on the
// falling edge and compared in order by each scenario task.
module tb_weight_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, pos_valid, pos_ready, pos_last, pos_empty;
  logic [7:0] in_data;
  logic [3:0] pc;
  logic [2:0] pos, pos_idx;

  logic        in_valid16, in_ready16, pos_valid16, pos_ready16, pos_last16, pos_empty16;
  logic [15:0] in_data16;
  logic [4:0]  pc16;
  logic [3:0]  pos16, pos_idx16;

  weight_streamer #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pc(pc), .pos_valid(pos_valid), .pos_ready(pos_ready), .pos(pos), .pos_idx(pos_idx),
    .pos_last(pos_last), .pos_empty(pos_empty)
  );

  weight_streamer #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
    .pc(pc16), .pos_valid(pos_valid16), .pos_ready(pos_ready16), .pos(pos16),
    .pos_idx(pos_idx16), .pos_last(pos_last16), .pos_empty(pos_empty16)
  );

  typedef struct {
    logic [25:0] beat;
    int          cyc;
  } obs_t;

  logic [25:0] exp_q[$];
  logic [25:0] exp16_q[$];
  obs_t        obs_q[$];
  obs_t        obs16_q[$];
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;

  function automatic logic [25:0] pack(input int p, input int i, input bit l, input bit e,
                                       input int c);
    return {8'(p), 8'(i), l, e, 8'(c)};
  endfunction

  // Model: one beat per set bit in ascending order, or a single empty beat.
  function automatic void push_word(input logic [15:0] word, input int w, input int max_beats,
                                    input bit wide);
    int n;
    int k;
    logic [25:0] b;
    n = 0;
    k = 0;
    for (int i = 0; i < w; i++) n += int'(word[i]);
    if (n == 0) begin
      b = pack(0, 0, 1'b1, 1'b1, 0);
      if (wide) exp16_q.push_back(b); else exp_q.push_back(b);
    end else begin
      for (int i = 0; i < w; i++) begin
        if (word[i]) begin
          b = pack(i, k, k == n - 1, 1'b0, n);
          if (k < max_beats) begin
            if (wide) exp16_q.push_back(b); else exp_q.push_back(b);
          end
          k++;
        end
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pos_valid === 1'b1 && pos_ready === 1'b1)
      obs_q.push_back('{beat: pack(int'(pos), int'(pos_idx), pos_last, pos_empty, int'(pc)),
                        cyc: cyc});
    if (pos_valid16 === 1'b1 && pos_ready16 === 1'b1)
      obs16_q.push_back('{beat: pack(int'(pos16), int'(pos_idx16), pos_last16, pos_empty16,
                                     int'(pc16)), cyc: cyc});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; pos_ready = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; pos_ready16 = 1'b0;
    tick();
    tick();
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b want=0", in_ready); else passed++;
    total++; if (in_ready16 !== 1'b0) $display("FAIL rst_in_ready16 got=%0b want=0", in_ready16); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%0b want=1", in_ready); else passed++;
    total++; if (pos_valid !== 1'b0) $display("FAIL rst_pos_valid got=%0b want=0", pos_valid); else passed++;
    total++; if (pos !== 3'd0 || pos_idx !== 3'd0) $display("FAIL rst_pos got=%0d/%0d want=0/0", pos, pos_idx); else passed++;
    total++; if (pos_last !== 1'b0 || pos_empty !== 1'b0) $display("FAIL rst_flags got=%0b%0b want=00", pos_last, pos_empty); else passed++;
    total++; if (pc !== 4'd0) $display("FAIL rst_pc got=%0d want=0", pc); else passed++;
    total++; if (pos_valid16 !== 1'b0) $display("FAIL rst_pos_valid16 got=%0b want=0", pos_valid16); else passed++;
    obs_q.delete(); obs16_q.delete();
  endtask

  task automatic test_d3();
    logic [25:0] e;
    obs_t o;
    push_word(16'h00D3, 8, 8, 1'b0);
    in_data = 8'hD3; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (pos_valid !== 1'b1) $display("FAIL d3_latency got=%0b want=1", pos_valid); else passed++;
    total++; if (pc !== 4'd5) $display("FAIL d3_pc got=%0d want=5", pc); else passed++;
    repeat (5) tick();
    total++; if (pos_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL d3_idle got=%0b%0b want=01", pos_valid, in_ready); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL d3_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL d3_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_zero();
    logic [25:0] e;
    obs_t o;
    push_word(16'h0000, 8, 8, 1'b0);
    in_data = 8'h00; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (pos_valid !== 1'b1 || pos_empty !== 1'b1 || pos_last !== 1'b1) $display("FAIL zero_flags got=%0b%0b%0b want=111", pos_valid, pos_empty, pos_last); else passed++;
    total++; if (pc !== 4'd0) $display("FAIL zero_pc got=%0d want=0", pc); else passed++;
    tick();
    total++; if (pos_valid !== 1'b0) $display("FAIL zero_idle got=%0b want=0", pos_valid); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL zero_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL zero_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    obs_t o;
    bit contiguous;
    push_word(16'h00FF, 8, 8, 1'b0);
    push_word(16'h0080, 8, 8, 1'b0);
    in_data = 8'hFF; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_data = 8'h80;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL b2b_mid_in_ready got=%0b want=0", in_ready); else passed++;
    total++; if (pc !== 4'd8) $display("FAIL b2b_pc_ff got=%0d want=8", pc); else passed++;
    repeat (7) tick();
    #1;
    total++; if (in_ready !== 1'b1 || pos !== 3'd7 || pos_last !== 1'b1) $display("FAIL b2b_last got=%0b/%0d/%0b want=1/7/1", in_ready, pos, pos_last); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (pos_valid !== 1'b1 || pos !== 3'd7 || pos_idx !== 3'd0 || pc !== 4'd1) $display("FAIL b2b_second got=%0b/%0d/%0d/%0d want=1/7/0/1", pos_valid, pos, pos_idx, pc); else passed++;
    tick();
    total++; if (pos_valid !== 1'b0) $display("FAIL b2b_idle got=%0b want=0", pos_valid); else passed++;
    contiguous = (obs_q.size() == 9);
    for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].cyc != obs_q[i-1].cyc + 1) contiguous = 1'b0;
    total++; if (!contiguous) $display("FAIL b2b_no_bubble got=%0d beats non-contiguous want=9 contiguous", obs_q.size()); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL b2b_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    logic [25:0] e;
    obs_t o;
    push_word(16'h0024, 8, 8, 1'b0);
    in_data = 8'h24; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_valid = 1'b0; pos_ready = 1'b0;
    tick();
    total++; if (pos_valid !== 1'b1 || pos !== 3'd2 || pos_idx !== 3'd0 || pos_last !== 1'b0 || pc !== 4'd2) $display("FAIL stall_hold1 got=%0b/%0d/%0d/%0b/%0d want=1/2/0/0/2", pos_valid, pos, pos_idx, pos_last, pc); else passed++;
    tick();
    total++; if (pos !== 3'd2 || pos_idx !== 3'd0 || pos_empty !== 1'b0) $display("FAIL stall_hold2 got=%0d/%0d/%0b want=2/0/0", pos, pos_idx, pos_empty); else passed++;
    pos_ready = 1'b1;
    tick();
    total++; if (pos !== 3'd5 || pos_idx !== 3'd1 || pos_last !== 1'b1) $display("FAIL stall_next got=%0d/%0d/%0b want=5/1/1", pos, pos_idx, pos_last); else passed++;
    tick();
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL stall_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [25:0] e;
    obs_t o;
    push_word(16'h00F0, 8, 2, 1'b0);
    in_data = 8'hF0; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    pos_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (pos_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rstmid_state got=%0b%0b want=01", pos_valid, in_ready); else passed++;
    total++; if (pc !== 4'd0 || pos_idx !== 3'd0) $display("FAIL rstmid_clear got=%0d/%0d want=0/0", pc, pos_idx); else passed++;
    push_word(16'h0001, 8, 8, 1'b0);
    in_data = 8'h01; in_valid = 1'b1; pos_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (pos !== 3'd0 || pos_last !== 1'b1 || pc !== 4'd1) $display("FAIL rstmid_next got=%0d/%0b/%0d want=0/1/1", pos, pos_last, pc); else passed++;
    tick();
    tick();
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL rstmid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL rstmid_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_w16();
    logic [25:0] e;
    obs_t o;
    push_word(16'h8001, 16, 16, 1'b1);
    in_data16 = 16'h8001; in_valid16 = 1'b1; pos_ready16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    total++; if (pc16 !== 5'd2 || pos16 !== 4'd0) $display("FAIL w16_first got=%0d/%0d want=2/0", pc16, pos16); else passed++;
    tick();
    total++; if (pos16 !== 4'd15 || pos_last16 !== 1'b1) $display("FAIL w16_second got=%0d/%0b want=15/1", pos16, pos_last16); else passed++;
    tick();
    total++; if (pos_valid16 !== 1'b0) $display("FAIL w16_idle got=%0b want=0", pos_valid16); else passed++;
    push_word(16'hFFFF, 16, 16, 1'b1);
    in_data16 = 16'hFFFF; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    total++; if (pc16 !== 5'd16) $display("FAIL w16_pc_full got=%0d want=16", pc16); else passed++;
    repeat (17) tick();
    total++; if (obs16_q.size() != exp16_q.size()) $display("FAIL w16_count got=%0d want=%0d", obs16_q.size(), exp16_q.size()); else passed++;
    while (exp16_q.size() > 0 && obs16_q.size() > 0) begin
      e = exp16_q.pop_front(); o = obs16_q.pop_front();
      total++; if (o.beat !== e) $display("FAIL w16_beat got=%h want=%h", o.beat, e); else passed++;
    end
    exp16_q.delete(); obs16_q.delete();
  endtask

  initial begin
    test_reset();
    test_d3();
    test_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_w16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

endmodule
